// File: rtl/regfile_pkg.sv
// Shared constants, state type and address-width helper for the multi-port register file.
package regfile_pkg;

  localparam int unsigned XLEN_DEFAULT  = 32;
  localparam int unsigned NREGS_DEFAULT = 32;

  typedef enum logic {
    RF_CLEAR,
    RF_READY
  } rf_state_t;

  // Address width for a register count; never narrower than one bit.
  function automatic int unsigned aw_of(input int unsigned nregs);
    return (nregs < 2) ? 1 : $clog2(nregs);
  endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// Clear sequencer: after reset, sweeps every register address once, writing zero,
// and holds busy high until the sweep completes.
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int unsigned NREGS = NREGS_DEFAULT,
  localparam int unsigned AW = aw_of(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  output logic          busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  localparam logic [AW-1:0] LastIdx = AW'(NREGS - 1);

  rf_state_t     state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;

  // Next-state: advance the sweep index and leave CLEAR after the last address.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    clr_we   = 1'b0;
    clr_addr = idx_q;
    if (state_q == RF_CLEAR) begin
      clr_we = ~rst;
      idx_d  = idx_q + 1'b1;
      if (idx_q == LastIdx) begin
        state_d = RF_READY;
      end
    end
  end

  // State register; reset restarts the sweep from address 0 in any state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RF_CLEAR;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // busy is a direct decode of the state flop, so it changes only on clock edges.
  assign busy = (state_q == RF_CLEAR);

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port integer register file with post-reset clear sweep.
// Optional write-to-read forwarding is enabled by defining REGFILE_MP_BYPASS_EN.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEFAULT,
  parameter int unsigned NREGS = NREGS_DEFAULT,
  parameter int unsigned NRD   = 2,
  localparam int unsigned AW = aw_of(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [XLEN-1:0]     wdata,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata,
  output logic                busy
);

  logic            clr_we;
  logic [AW-1:0]   clr_addr;
  logic            user_we;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [XLEN-1:0] wr_data;

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];

  regfile_clear_fsm #(
    .NREGS (NREGS)
  ) u_clear_fsm (
    .clk      (clk),
    .rst      (rst),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // User writes only land in READY and never touch x0; the sweep owns the port while busy.
  assign user_we = we & ~busy & ~rst & (waddr != '0);
  assign wr_en   = clr_we | user_we;
  assign wr_addr = clr_we ? clr_addr : waddr;
  assign wr_data = clr_we ? '0 : wdata;

  // Storage next-state: single write port shared by the sweep and writeback.
  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[wr_addr] = wr_data;
    end
  end

  // Storage flops; no reset, contents are zeroed by the sweep instead.
  always_ff @(posedge clk) begin
    regs_q <= regs_d;
  end

`ifdef REGFILE_MP_BYPASS_EN
  logic fwd_en;
  assign fwd_en = we & ~busy & (waddr != '0);
`endif

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rd;

    assign ra = raddr[i*AW +: AW];

    // Read mux: busy and x0 force zero ahead of any forwarding.
    always_comb begin
      rd = regs_q[ra];
`ifdef REGFILE_MP_BYPASS_EN
      if (fwd_en && (waddr == ra)) begin
        rd = wdata;
      end
`endif
      if (busy || (ra == '0)) begin
        rd = '0;
      end
    end

    assign rdata[i*XLEN +: XLEN] = rd;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (default and NRD=3/XLEN=64 instances).
module tb_regfile_mp;

  logic         clk;
  logic         rst;
  logic         we;
  logic [4:0]   waddr;
  logic [31:0]  wdata;
  logic [9:0]   raddr;
  logic [63:0]  rdata;
  logic         busy;

  logic         we6;
  logic [4:0]   waddr6;
  logic [63:0]  wdata6;
  logic [14:0]  raddr6;
  logic [191:0] rdata6;
  logic         busy6;

  int total = 0;
  int bad   = 0;
  int cnt;

  regfile_mp dut (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (raddr),
    .rdata (rdata),
    .busy  (busy)
  );

  regfile_mp #(
    .XLEN  (64),
    .NREGS (32),
    .NRD   (3)
  ) dut6 (
    .clk   (clk),
    .rst   (rst),
    .we    (we6),
    .waddr (waddr6),
    .wdata (wdata6),
    .raddr (raddr6),
    .rdata (rdata6),
    .busy  (busy6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst    = 1'b1;
    we     = 1'b0;
    waddr  = '0;
    wdata  = '0;
    raddr  = '0;
    we6    = 1'b0;
    waddr6 = '0;
    wdata6 = '0;
    raddr6 = '0;

    // 1. Reset sweep, with a dropped write at sweep cycle 10.
    step();
    chk("rst_busy", 64'(busy), 64'd1);
    raddr = {5'd5, 5'd5};
    #1;
    chk("busy_rd0_zero", 64'(rdata[31:0]), 64'd0);
    chk("busy_rd1_zero", 64'(rdata[63:32]), 64'd0);
    rst = 1'b0;
    #1;
    chk("busy_after_release", 64'(busy), 64'd1);
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      we    = (cnt == 10);
      waddr = 5'd7;
      wdata = 32'hAAAA_5555;
      step();
      cnt++;
    end
    we = 1'b0;
    chk("sweep_len", 64'(cnt), 64'd32);
    chk("busy6_idle", 64'(busy6), 64'd0);
    for (int a = 0; a < 32; a++) begin
      raddr = {5'(a), 5'(a)};
      #1;
      chk($sformatf("clr_p0_a%0d", a), 64'(rdata[31:0]), 64'd0);
      chk($sformatf("clr_p1_a%0d", a), 64'(rdata[63:32]), 64'd0);
    end
    raddr = {5'd7, 5'd7};
    #1;
    chk("busy_write_dropped", 64'(rdata[31:0]), 64'd0);

    // 2. Write/read in READY; writes to x0 discarded.
    we    = 1'b1;
    waddr = 5'd5;
    wdata = 32'hDEAD_BEEF;
    step();
    we    = 1'b0;
    raddr = {5'd5, 5'd5};
    #1;
    chk("wr5_p0", 64'(rdata[31:0]), 64'hDEAD_BEEF);
    chk("wr5_p1", 64'(rdata[63:32]), 64'hDEAD_BEEF);
    we    = 1'b1;
    waddr = 5'd0;
    wdata = 32'h0000_1234;
    raddr = {5'd5, 5'd0};
    step();
    we = 1'b0;
    #1;
    chk("x0_zero", 64'(rdata[31:0]), 64'd0);
    chk("wr5_kept", 64'(rdata[63:32]), 64'hDEAD_BEEF);

    // 5. Same-cycle collision on address 9.
    we    = 1'b1;
    waddr = 5'd9;
    wdata = 32'h11;
    step();
    wdata = 32'h22;
    raddr = {5'd5, 5'd9};
    #1;
`ifdef REGFILE_MP_BYPASS_EN
    chk("collide_same_cycle", 64'(rdata[31:0]), 64'h22);
`else
    chk("collide_same_cycle", 64'(rdata[31:0]), 64'h11);
`endif
    chk("collide_other_port", 64'(rdata[63:32]), 64'hDEAD_BEEF);
    step();
    we = 1'b0;
    #1;
    chk("collide_next_cycle", 64'(rdata[31:0]), 64'h22);

    // 4. Fill 1..31, then reset, and reset again at sweep cycle 20.
    for (int a = 1; a < 32; a++) begin
      we    = 1'b1;
      waddr = 5'(a);
      wdata = 32'(a);
      step();
    end
    we    = 1'b0;
    raddr = {5'd31, 5'd20};
    #1;
    chk("fill_a20", 64'(rdata[31:0]), 64'd20);
    chk("fill_a31", 64'(rdata[63:32]), 64'd31);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("busy_hides_a31", 64'(rdata[63:32]), 64'd0);
    for (int e = 0; e < 20; e++) step();
    chk("busy_mid_sweep", 64'(busy), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      step();
      cnt++;
    end
    chk("resweep_len", 64'(cnt), 64'd32);
    for (int a = 0; a < 32; a++) begin
      raddr = {5'(a), 5'(a)};
      #1;
      chk($sformatf("reclr_p0_a%0d", a), 64'(rdata[31:0]), 64'd0);
      chk($sformatf("reclr_p1_a%0d", a), 64'(rdata[63:32]), 64'd0);
    end

    // 6. Three ports, 64-bit data.
    chk("busy6_ready", 64'(busy6), 64'd0);
    we6    = 1'b1;
    waddr6 = 5'd31;
    wdata6 = 64'h0123_4567_89AB_CDEF;
    step();
    we6    = 1'b0;
    raddr6 = {5'd31, 5'd0, 5'd31};
    #1;
    chk("p3_port0", rdata6[63:0], 64'h0123_4567_89AB_CDEF);
    chk("p3_port1", rdata6[127:64], 64'd0);
    chk("p3_port2", rdata6[191:128], 64'h0123_4567_89AB_CDEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
